// File: rtl/led_sequencer.sv
// One-hot LED step sequencer: rotate up/down, ping-pong and all-blink, active-low outputs.
// Optional PWM dimming of lit channels is compiled in when LED_PWM_EN is defined.
module led_sequencer #(
   parameter int CHANNELS  = 3,
   parameter int CNT_WIDTH = 32,
   parameter int PWM_BITS  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [CNT_WIDTH-1:0] period,
   input  logic [1:0]           mode,
   input  logic [PWM_BITS-1:0]  duty,
   output logic [CHANNELS-1:0]  led,
   output logic                 step_pulse
);
   typedef enum logic [1:0] {
      MODE_UP    = 2'd0,
      MODE_DOWN  = 2'd1,
      MODE_PING  = 2'd2,
      MODE_BLINK = 2'd3
   } mode_t;

   // With a single channel the ping-pong ends coincide, so direction never flips.
   localparam bit MULTI = (CHANNELS > 1);

   mode_t                mode_sel;
   logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
   logic [CNT_WIDTH-1:0] period_last;
   logic [CHANNELS-1:0]  step_reg, step_next;
   logic [CHANNELS-1:0]  rot_left, rot_right;
   logic [CHANNELS-1:0]  lit;
   logic                 dir_reg, dir_next;
   logic                 phase_reg, phase_next;
   logic                 wrap, boundary, pwm_on;

   assign mode_sel    = mode_t'(mode);
   assign period_last = (period == '0) ? '0 : period - CNT_WIDTH'(1);
   assign wrap        = (cnt_reg >= period_last);
   assign boundary    = en & wrap;

   generate
      if (CHANNELS == 1) begin : g_single
         assign rot_left  = step_reg;
         assign rot_right = step_reg;
      end else begin : g_multi
         assign rot_left  = {step_reg[CHANNELS-2:0], step_reg[CHANNELS-1]};
         assign rot_right = {step_reg[0], step_reg[CHANNELS-1:1]};
      end
   endgenerate

   always_comb begin
      cnt_next   = cnt_reg;
      step_next  = step_reg;
      dir_next   = dir_reg;
      phase_next = phase_reg;
      if (boundary) begin
         cnt_next = '0;
         if (mode_sel != MODE_BLINK) phase_next = 1'b0;
         case (mode_sel)
            MODE_UP:   step_next = rot_left;
            MODE_DOWN: step_next = rot_right;
            MODE_PING: begin
               // Bounce off the ends without repeating the end channel.
               if (MULTI && dir_reg && step_reg[CHANNELS-1]) begin
                  dir_next  = 1'b0;
                  step_next = rot_right;
               end else if (MULTI && !dir_reg && step_reg[0]) begin
                  dir_next  = 1'b1;
                  step_next = rot_left;
               end else if (dir_reg) begin
                  step_next = rot_left;
               end else begin
                  step_next = rot_right;
               end
            end
            MODE_BLINK: phase_next = ~phase_reg;
            default:    step_next  = step_reg;
         endcase
      end else if (en) begin
         cnt_next = cnt_reg + CNT_WIDTH'(1);
      end
   end

   always_comb begin
      if (mode_sel == MODE_BLINK) lit = {CHANNELS{phase_reg}};
      else                        lit = step_reg;
   end

`ifdef LED_PWM_EN
   logic [PWM_BITS-1:0] pwm_cnt_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) pwm_cnt_reg <= '0;
      else      pwm_cnt_reg <= pwm_cnt_reg + PWM_BITS'(1);
   end

   // All-ones duty means fully on, otherwise the compare would leave one dark slot.
   assign pwm_on = (&duty) | (pwm_cnt_reg < duty);
`else
   logic unused_duty;
   assign unused_duty = ^duty;
   assign pwm_on      = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_reg    <= '0;
         step_reg   <= CHANNELS'(1);
         dir_reg    <= 1'b1;
         phase_reg  <= 1'b0;
         step_pulse <= 1'b0;
         led        <= '1;
      end else begin
         cnt_reg    <= cnt_next;
         step_reg   <= step_next;
         dir_reg    <= dir_next;
         phase_reg  <= phase_next;
         step_pulse <= boundary;
         led        <= ~(lit & {CHANNELS{pwm_on}});
      end
   end
endmodule
